// File: rtl/transpose_wr_fsm_pkg.sv
// Shared sizes, state encoding and address helper for the transpose write sequencer.
package transpose_wr_fsm_pkg;

  localparam int unsigned BASE_TIN  = 64;
  localparam int unsigned TOUT      = 32;
  localparam int unsigned NSLOT     = 2;
  localparam int unsigned PIX_W     = 12;
  localparam int unsigned LOG2_TIN  = $clog2(BASE_TIN);
  localparam int unsigned LOG2_TOUT = $clog2(TOUT);
  localparam int unsigned SLOT_W    = $clog2(NSLOT);
  localparam int unsigned ADDR_W    = $clog2(NSLOT * TOUT);
  localparam int unsigned OCC_W     = $clog2(NSLOT + 1);
  localparam int unsigned CH_W      = PIX_W - LOG2_TIN;
  localparam int unsigned PG_W      = PIX_W - LOG2_TOUT;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [SLOT_W-1:0]    slot;
    logic [LOG2_TOUT-1:0] len_m1;
  } blk_info_t;

  // TOUT is a power of two, so slot*TOUT is a shift.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0]    slot,
                                                  input logic [LOG2_TOUT-1:0] pix);
    return (ADDR_W'(slot) << LOG2_TOUT) | ADDR_W'(pix);
  endfunction

endpackage

// File: rtl/transpose_wr_fsm_if.sv
// Beat stream, buffer write port and block announce/release channel of the write sequencer.
interface transpose_wr_fsm_if;
  import transpose_wr_fsm_pkg::*;

  logic                 in_vld;
  logic                 in_rdy;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 blk_vld;
  logic [SLOT_W-1:0]    blk_slot;
  logic [LOG2_TOUT-1:0] blk_len_m1;
  logic                 rd_release;

  modport master (
    output in_vld, rd_release,
    input  in_rdy, wr_en, wr_addr, blk_vld, blk_slot, blk_len_m1
  );

  modport slave (
    input  in_vld, rd_release,
    output in_rdy, wr_en, wr_addr, blk_vld, blk_slot, blk_len_m1
  );

endinterface

// File: rtl/transpose_slot_tracker.sv
// Slot occupancy, write-slot pointer and input-ready gating for the transpose buffer.
module transpose_slot_tracker
  import transpose_wr_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              blk_done_i,
  input  logic              rd_release_i,
  output logic              in_rdy_o,
  output logic [SLOT_W-1:0] wr_slot_o
);

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic              rel_ok;

  // A release against an empty buffer is dropped; fill and release together cancel.
  always_comb begin
    rel_ok    = rd_release_i && (occ_q != '0);
    occ_d     = occ_q;
    wr_slot_d = wr_slot_q;
    if (blk_done_i && !rel_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!blk_done_i && rel_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (blk_done_i) begin
      wr_slot_d = wr_slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= '0;
      wr_slot_q <= '0;
    end else begin
      occ_q     <= occ_d;
      wr_slot_q <= wr_slot_d;
    end
  end

  assign in_rdy_o  = run_i && (occ_q != OCC_W'(NSLOT));
  assign wr_slot_o = wr_slot_q;

endmodule

// File: rtl/transpose_wr_fsm.sv
// Write-side sequencer of the transpose stage: walks pixel/channel/pixel-group loops into slot buffers.
module transpose_wr_fsm
  import transpose_wr_fsm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [PIX_W-1:0]     pixel_in_i,
  input  logic [PIX_W-1:0]     pixel_out_i,
  transpose_wr_fsm_if.slave    bus,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e               state_q, state_d;
  logic [LOG2_TOUT-1:0] pix_cnt_q, pix_cnt_d;
  logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d, ch_last_q, ch_last_d;
  logic [PG_W-1:0]      pg_cnt_q, pg_cnt_d, pg_last_q, pg_last_d;
  logic [LOG2_TOUT-1:0] tail_q, tail_d;
  logic                 done_q, done_d, blk_vld_q, blk_vld_d;
  blk_info_t            blk_q, blk_d;

  logic                 in_rdy_c, beat_c, blk_end_c, ch_wrap_c, last_beat_c, frame_ok_c;
  logic [LOG2_TOUT-1:0] cur_len_m1_c;
  logic [SLOT_W-1:0]    wr_slot_c;
  logic [PIX_W-1:0]     pin_m1_c, pout_m1_c;

  transpose_slot_tracker u_trk (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (state_q == RUN),
    .blk_done_i   (blk_end_c),
    .rd_release_i (bus.rd_release),
    .in_rdy_o     (in_rdy_c),
    .wr_slot_o    (wr_slot_c)
  );

  assign pin_m1_c     = pixel_in_i - PIX_W'(1);
  assign pout_m1_c    = pixel_out_i - PIX_W'(1);
  assign frame_ok_c   = start_i && (pixel_in_i != '0) && (pixel_out_i != '0);
  assign beat_c       = bus.in_vld && in_rdy_c;
  assign cur_len_m1_c = (pg_cnt_q == pg_last_q) ? tail_q : LOG2_TOUT'(TOUT - 1);
  assign blk_end_c    = beat_c && (pix_cnt_q == cur_len_m1_c);
  assign ch_wrap_c    = (ch_cnt_q == ch_last_q);
  assign last_beat_c  = blk_end_c && ch_wrap_c && (pg_cnt_q == pg_last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_ok_c)  state_d = RUN;
      RUN:     if (last_beat_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loop counters run innermost pixel, then channel group, then pixel group.
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    pg_cnt_d  = pg_cnt_q;
    ch_last_d = ch_last_q;
    pg_last_d = pg_last_q;
    tail_d    = tail_q;
    done_d    = 1'b0;
    blk_vld_d = 1'b0;
    blk_d     = blk_q;
    if (state_q == IDLE) begin
      if (frame_ok_c) begin
        pix_cnt_d = '0;
        ch_cnt_d  = '0;
        pg_cnt_d  = '0;
        ch_last_d = CH_W'(pout_m1_c >> LOG2_TIN);
        pg_last_d = PG_W'(pin_m1_c >> LOG2_TOUT);
        tail_d    = pin_m1_c[LOG2_TOUT-1:0];
      end
    end else if (beat_c) begin
      if (blk_end_c) begin
        pix_cnt_d = '0;
        blk_vld_d = 1'b1;
        blk_d     = '{slot: wr_slot_c, len_m1: cur_len_m1_c};
        done_d    = last_beat_c;
        if (ch_wrap_c) begin
          ch_cnt_d = '0;
          pg_cnt_d = pg_cnt_q + PG_W'(1);
        end else begin
          ch_cnt_d = ch_cnt_q + CH_W'(1);
        end
      end else begin
        pix_cnt_d = pix_cnt_q + LOG2_TOUT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q <= '0;
      ch_cnt_q  <= '0;
      pg_cnt_q  <= '0;
      ch_last_q <= '0;
      pg_last_q <= '0;
      tail_q    <= '0;
      done_q    <= 1'b0;
      blk_vld_q <= 1'b0;
      blk_q     <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      pg_cnt_q  <= pg_cnt_d;
      ch_last_q <= ch_last_d;
      pg_last_q <= pg_last_d;
      tail_q    <= tail_d;
      done_q    <= done_d;
      blk_vld_q <= blk_vld_d;
      blk_q     <= blk_d;
    end
  end

  assign bus.in_rdy     = in_rdy_c;
  assign bus.wr_en      = beat_c;
  assign bus.wr_addr    = slot_addr(wr_slot_c, pix_cnt_q);
  assign bus.blk_vld    = blk_vld_q;
  assign bus.blk_slot   = blk_q.slot;
  assign bus.blk_len_m1 = blk_q.len_m1;
  assign busy_o         = (state_q == RUN);
  assign done_o         = done_q;

endmodule
